// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 Hz VGA path, plus the colour
// codes the downstream pattern generator uses. Imported by vga_sync_gen,
// vga_axis_counter and the pattern generator.
//   DEF_*      : default visible / porch / sync widths for each axis
//   H_TOTAL    : pixels per line   (800)
//   V_TOTAL    : lines per frame   (525)
//   CNT_W      : width of the internal h/v counters
//   COL_W/ROW_W: widths of the column/row coordinate outputs
//   COLOR_*    : 12-bit RGB444 colour codes
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;

  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned COL_W = 10;
  localparam int unsigned ROW_W = 9;
  localparam int unsigned RGB_W = 12;

  localparam logic [RGB_W-1:0] COLOR_BLACK   = 12'h000;
  localparam logic [RGB_W-1:0] COLOR_WHITE   = 12'hFFF;
  localparam logic [RGB_W-1:0] COLOR_RED     = 12'hF00;
  localparam logic [RGB_W-1:0] COLOR_GREEN   = 12'h0F0;
  localparam logic [RGB_W-1:0] COLOR_BLUE    = 12'h00F;
  localparam logic [RGB_W-1:0] COLOR_YELLOW  = 12'hFF0;
  localparam logic [RGB_W-1:0] COLOR_CYAN    = 12'h0FF;
  localparam logic [RGB_W-1:0] COLOR_MAGENTA = 12'hF0F;

  // Total length of one axis from its four segment widths.
  function automatic int unsigned axis_total(
    input int unsigned visible,
    input int unsigned front,
    input int unsigned sync,
    input int unsigned back
  );
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping counter for one VGA axis (horizontal pixels or vertical lines).
// Counts 0..TOTAL-1 while en_i is high and decodes position flags from the
// current count.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : advance enable
//   cnt_o         : current count
//   wrap_o        : count is at (or beyond) the last position
//   visible_o     : count is inside the visible segment
//   sync_o        : count is inside the sync pulse
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned W          = CNT_W,
  parameter int unsigned TOTAL      = H_TOTAL,
  parameter int unsigned VISIBLE    = DEF_H_VISIBLE,
  parameter int unsigned SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT,
  parameter int unsigned SYNC_LEN   = DEF_H_SYNC
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o,
  output logic         visible_o,
  output logic         sync_o
);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END    = W'(VISIBLE);
  localparam logic [W-1:0] SYNC_FIRST = W'(SYNC_START);
  localparam logic [W-1:0] SYNC_LAST  = W'(SYNC_START + SYNC_LEN - 1);

  logic [W-1:0] cnt_d, cnt_q;
  logic         wrap;

  // >= rather than == so an out-of-range count recovers on the next advance.
  assign wrap = (cnt_q >= LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign wrap_o    = wrap;
  assign visible_o = (cnt_q < VIS_END);
  assign sync_o    = (cnt_q >= SYNC_FIRST) && (cnt_q <= SYNC_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 Hz timing generator. Runs horizontal/vertical counters and
// registers the sync, blanking and coordinate decodes (1 tick latency, all
// outputs aligned).
//   clk_i         : pixel clock (25 MHz; 50 MHz with VGA_PIXEL_DIV_EN)
//   rst_ni        : asynchronous active-low reset
//   hsync_o       : horizontal sync, active level SYNC_POL
//   vsync_o       : vertical sync, active level SYNC_POL
//   video_on_o    : inside the visible window
//   column_o      : pixel column, 0 outside the window
//   row_o         : pixel row, 0 outside the window
//   frame_start_o : one-tick pulse at pixel (0,0)
// Build option: define VGA_PIXEL_DIV_EN to run from a 2x clock; an internal
// toggle makes a pixel tick every second clock.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             video_on_o,
  output logic [COL_W-1:0] column_o,
  output logic [ROW_W-1:0] row_o,
  output logic             frame_start_o
);

  localparam int unsigned LINE_TOTAL  = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned FRAME_LINES = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  logic pix_en;

`ifdef VGA_PIXEL_DIV_EN
  logic pix_en_d, pix_en_q;

  assign pix_en_d = ~pix_en_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_en_q <= 1'b0;
    end else begin
      pix_en_q <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;
`else
  assign pix_en = 1'b1;
`endif

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, h_vis, h_sync;
  logic             v_vis, v_sync;
  logic             v_wrap_unused;
  logic             v_msb_unused;

  vga_axis_counter #(
    .W          (CNT_W),
    .TOTAL      (LINE_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (pix_en),
    .cnt_o     (h_cnt),
    .wrap_o    (h_wrap),
    .visible_o (h_vis),
    .sync_o    (h_sync)
  );

  vga_axis_counter #(
    .W          (CNT_W),
    .TOTAL      (FRAME_LINES),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (pix_en & h_wrap),
    .cnt_o     (v_cnt),
    .wrap_o    (v_wrap_unused),
    .visible_o (v_vis),
    .sync_o    (v_sync)
  );

  // Row MSB only matters outside the visible window, where row_o is forced 0.
  assign v_msb_unused = v_cnt[CNT_W-1];

  logic             hsync_d, hsync_q;
  logic             vsync_d, vsync_q;
  logic             video_on_d, video_on_q;
  logic [COL_W-1:0] column_d, column_q;
  logic [ROW_W-1:0] row_d, row_q;
  logic             frame_start_d, frame_start_q;

  // Output registers hold between pixel ticks so levels stretch with the tick.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    column_d      = column_q;
    row_d         = row_q;
    frame_start_d = frame_start_q;
    if (pix_en) begin
      hsync_d       = h_sync ? SYNC_POL : ~SYNC_POL;
      vsync_d       = v_sync ? SYNC_POL : ~SYNC_POL;
      video_on_d    = h_vis & v_vis;
      column_d      = (h_vis & v_vis) ? h_cnt[COL_W-1:0] : '0;
      row_d         = (h_vis & v_vis) ? v_cnt[ROW_W-1:0] : '0;
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      column_q      <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      column_q      <= column_d;
      row_q         <= row_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_on_o    = video_on_q;
  assign column_o      = column_q;
  assign row_o         = row_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default 640x480 instance for reset,
// line timing, coordinates and mid-frame reset, plus a shrunken-geometry
// instance (16 x 12) so whole frames, vsync and the double wrap fit in a short run.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

`ifdef VGA_PIXEL_DIV_EN
  localparam int unsigned DIV = 2;
`else
  localparam int unsigned DIV = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic             hs, vs, von, fs;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic             s_hs, s_vs, s_von, s_fs;
  logic [COL_W-1:0] s_col;
  logic [ROW_W-1:0] s_row;

  vga_sync_gen u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .hsync_o       (hs),
    .vsync_o       (vs),
    .video_on_o    (von),
    .column_o      (col),
    .row_o         (row),
    .frame_start_o (fs)
  );

  // Small geometry: line 8+2+3+3 = 16, frame 6+2+2+2 = 12 lines.
  vga_sync_gen #(
    .H_VISIBLE (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (3),
    .V_VISIBLE (6),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (2),
    .SYNC_POL  (1'b0)
  ) u_small (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .hsync_o       (s_hs),
    .vsync_o       (s_vs),
    .video_on_o    (s_von),
    .column_o      (s_col),
    .row_o         (s_row),
    .frame_start_o (s_fs)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  initial begin
    int h, v;
    logic exp_von;

    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_hsync", 32'(hs), 32'd1);
    check("rst_vsync", 32'(vs), 32'd1);
    check("rst_video", 32'(von), 32'd0);
    check("rst_col", 32'(col), 32'd0);
    check("rst_row", 32'(row), 32'd0);
    check("rst_fs", 32'(fs), 32'd0);

    rst_n = 1'b1;
`ifdef VGA_PIXEL_DIV_EN
    @(posedge clk); #1;
    check("div_first_clk_hold_video", 32'(von), 32'd0);
    check("div_first_clk_hold_fs", 32'(fs), 32'd0);
    @(posedge clk); #1;
`else
    @(posedge clk); #1;
`endif
    check("first_fs", 32'(fs), 32'd1);
    check("first_video", 32'(von), 32'd1);
    check("first_col", 32'(col), 32'd0);
    check("first_row", 32'(row), 32'd0);

    // Line 0 pixel by pixel.
    for (int t = 0; t < 800; t++) begin
      check("line_col", 32'(col), (t < 640) ? 32'(t) : 32'd0);
      check("line_video", 32'(von), 32'(t < 640));
      check("line_hsync", 32'(hs), 32'(!(t >= 656 && t <= 751)));
      check("line_vsync", 32'(vs), 32'd1);
      check("line_row", 32'(row), 32'd0);
      check("line_fs", 32'(fs), 32'(t == 0));
`ifdef VGA_PIXEL_DIV_EN
      if (t == 5) begin
        @(posedge clk); #1;
        check("div_col_hold", 32'(col), 32'd5);
        @(posedge clk); #1;
      end else begin
        tick();
      end
`else
      tick();
`endif
    end

    check("line1_col", 32'(col), 32'd0);
    check("line1_video", 32'(von), 32'd1);
    check("line1_row", 32'(row), 32'd1);
    check("line1_fs", 32'(fs), 32'd0);

    repeat (900) tick();
    check("l2p100_row", 32'(row), 32'd2);
    check("l2p100_col", 32'(col), 32'd100);
    check("l2p100_video", 32'(von), 32'd1);

    // Mid-frame reset, asserted and released away from clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_col", 32'(col), 32'd0);
    check("mid_rst_row", 32'(row), 32'd0);
    check("mid_rst_video", 32'(von), 32'd0);
    check("mid_rst_hsync", 32'(hs), 32'd1);
    check("mid_rst_fs", 32'(fs), 32'd0);
    check("mid_rst_small_video", 32'(s_von), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_fs", 32'(fs), 32'd1);
    check("post_rst_video", 32'(von), 32'd1);
    check("post_rst_col", 32'(col), 32'd0);

    // Two full frames on the small instance, including the h+v double wrap.
    for (int t = 0; t < 384; t++) begin
      h = t % 16;
      v = (t / 16) % 12;
      exp_von = (h < 8) && (v < 6);
      check("sm_video", 32'(s_von), 32'(exp_von));
      check("sm_col", 32'(s_col), exp_von ? 32'(h) : 32'd0);
      check("sm_row", 32'(s_row), exp_von ? 32'(v) : 32'd0);
      check("sm_hsync", 32'(s_hs), 32'(!(h >= 10 && h <= 12)));
      check("sm_vsync", 32'(s_vs), 32'(!(v >= 8 && v <= 9)));
      check("sm_fs", 32'(s_fs), 32'(h == 0 && v == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
